// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read-arbiter state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_ERR   = 3'd3,
    ST_DRAIN = 3'd4
  } arb_rd_state_t;

endpackage

// File: rtl/axi4_lite_rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side opposite last_grant.
module axi4_lite_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Round-robin AXI4-Lite read arbiter for two masters onto one slave, with a
// data-phase timeout that answers SLVERR and then drains the late slave beat.
module axi4_lite_read_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] REQ0_ARADDR,
  input  logic                  REQ0_ARVALID,
  output logic                  REQ0_ARREADY,
  output logic [DATA_WIDTH-1:0] REQ0_RDATA,
  output logic [1:0]            REQ0_RRESP,
  output logic                  REQ0_RVALID,
  input  logic                  REQ0_RREADY,
  input  logic [ADDR_WIDTH-1:0] REQ1_ARADDR,
  input  logic                  REQ1_ARVALID,
  output logic                  REQ1_ARREADY,
  output logic [DATA_WIDTH-1:0] REQ1_RDATA,
  output logic [1:0]            REQ1_RRESP,
  output logic                  REQ1_RVALID,
  input  logic                  REQ1_RREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic                  timeout,
  output logic                  busy
);

  // Width kept at least 1 so a disabled timeout still elaborates cleanly.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_rd_state_t         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  grant_reg, grant_next;
  logic                  last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  timeout_reg, timeout_next;

  logic [1:0]            req_valid, rr_gnt, arready_vec, rready_vec, rvalid_vec;
  logic                  rr_valid;
  logic                  m_arvalid, m_rready, r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic [DATA_WIDTH-1:0] rdata_vec [2];
  logic [1:0]            rresp_vec [2];

  assign req_valid  = {REQ1_ARVALID, REQ0_ARVALID};
  assign rready_vec = {REQ1_RREADY, REQ0_RREADY};

  axi4_lite_rr_arbiter2 u_rr (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .gnt        (rr_gnt),
    .valid      (rr_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      timeout_reg    <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    timeout_next    = 1'b0;
    arready_vec     = '0;
    m_arvalid       = 1'b0;
    m_rready        = 1'b0;
    r_valid         = 1'b0;
    r_data          = '0;
    r_resp          = AXI_RESP_OKAY;
    unique case (state_reg)
      ST_IDLE: begin
        arready_vec = rr_gnt;
        if (rr_valid) begin
          addr_next       = rr_gnt[1] ? REQ1_ARADDR : REQ0_ARADDR;
          grant_next      = rr_gnt[1];
          last_grant_next = rr_gnt[1];
          state_next      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_arvalid = 1'b1;
        if (M_AXI_ARREADY) begin
          cnt_next   = '0;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        r_valid  = M_AXI_RVALID;
        r_data   = M_AXI_RDATA;
        r_resp   = M_AXI_RRESP;
        m_rready = rready_vec[grant_reg];
        // A beat on the threshold cycle takes priority over the timeout.
        if (M_AXI_RVALID) begin
          if (rready_vec[grant_reg]) state_next = ST_IDLE;
        end else if (TIMEOUT_CYCLES > 0) begin
          if (cnt_reg == CNT_LAST) begin
            state_next   = ST_ERR;
            timeout_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_ERR: begin
        r_valid = 1'b1;
        r_resp  = AXI_RESP_SLVERR;
        if (rready_vec[grant_reg]) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        m_rready = 1'b1;
        if (M_AXI_RVALID) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    localparam logic IDX = 1'(gi);
    assign rvalid_vec[gi] = r_valid && (grant_reg == IDX);
    assign rdata_vec[gi]  = (grant_reg == IDX) ? r_data : '0;
    assign rresp_vec[gi]  = (grant_reg == IDX) ? r_resp : '0;
  end

  assign REQ0_ARREADY  = arready_vec[0];
  assign REQ1_ARREADY  = arready_vec[1];
  assign REQ0_RVALID   = rvalid_vec[0];
  assign REQ1_RVALID   = rvalid_vec[1];
  assign REQ0_RDATA    = rdata_vec[0];
  assign REQ1_RDATA    = rdata_vec[1];
  assign REQ0_RRESP    = rresp_vec[0];
  assign REQ1_RRESP    = rresp_vec[1];
  assign M_AXI_ARADDR  = m_arvalid ? addr_reg : '0;
  assign M_AXI_ARVALID = m_arvalid;
  assign M_AXI_RREADY  = m_rready;
  assign timeout       = timeout_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Self-checking bench: hand-written vector table, reset-in-DATA sequence, and
// random transactions predicted by a transaction-level arbitration/timeout model.
module tb_axi4_lite_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] REQ0_ARADDR, REQ1_ARADDR, M_AXI_ARADDR;
  logic          REQ0_ARVALID, REQ1_ARVALID, REQ0_ARREADY, REQ1_ARREADY;
  logic [DW-1:0] REQ0_RDATA, REQ1_RDATA, M_AXI_RDATA;
  logic [1:0]    REQ0_RRESP, REQ1_RRESP, M_AXI_RRESP;
  logic          REQ0_RVALID, REQ1_RVALID, REQ0_RREADY, REQ1_RREADY;
  logic          M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic          timeout, busy;

  int checks = 0;
  int errors = 0;
  int model_last = 1;

  axi4_lite_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .REQ0_ARADDR(REQ0_ARADDR), .REQ0_ARVALID(REQ0_ARVALID), .REQ0_ARREADY(REQ0_ARREADY),
    .REQ0_RDATA(REQ0_RDATA), .REQ0_RRESP(REQ0_RRESP), .REQ0_RVALID(REQ0_RVALID), .REQ0_RREADY(REQ0_RREADY),
    .REQ1_ARADDR(REQ1_ARADDR), .REQ1_ARVALID(REQ1_ARVALID), .REQ1_ARREADY(REQ1_ARREADY),
    .REQ1_RDATA(REQ1_RDATA), .REQ1_RRESP(REQ1_RRESP), .REQ1_RVALID(REQ1_RVALID), .REQ1_RREADY(REQ1_RREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          v0, v1;
    logic [31:0] a0, a1;
    int          arw, d;
    logic [31:0] data;
    logic [1:0]  resp;
    int          rr;
    int          eg;
    logic [1:0]  eresp;
    logic [31:0] edata;
    bit          eto;
  } txn_t;

  function automatic txn_t mk(bit r, bit v0, bit v1, logic [31:0] a0, logic [31:0] a1,
                              int arw, int d, logic [31:0] data, logic [1:0] resp, int rr,
                              int eg, logic [1:0] eresp, logic [31:0] edata, bit eto);
    txn_t t;
    t.rst = r; t.v0 = v0; t.v1 = v1; t.a0 = a0; t.a1 = a1; t.arw = arw; t.d = d;
    t.data = data; t.resp = resp; t.rr = rr; t.eg = eg; t.eresp = eresp; t.edata = edata; t.eto = eto;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic g_rvalid(int g);
    return g ? REQ1_RVALID : REQ0_RVALID;
  endfunction
  function automatic logic [DW-1:0] g_rdata(int g);
    return g ? REQ1_RDATA : REQ0_RDATA;
  endfunction
  function automatic logic [1:0] g_rresp(int g);
    return g ? REQ1_RRESP : REQ0_RRESP;
  endfunction
  function automatic logic other_r(int g);
    return g ? |{REQ0_RVALID, REQ0_RDATA, REQ0_RRESP} : |{REQ1_RVALID, REQ1_RDATA, REQ1_RRESP};
  endfunction
  function automatic logic any_out();
    return |{REQ0_ARREADY, REQ1_ARREADY, REQ0_RDATA, REQ0_RRESP, REQ0_RVALID,
             REQ1_RDATA, REQ1_RRESP, REQ1_RVALID, M_AXI_ARADDR, M_AXI_ARVALID,
             M_AXI_RREADY, timeout, busy};
  endfunction

  task automatic set_rready(input int g, input logic v);
    if (g != 0) REQ1_RREADY = v;
    else        REQ0_RREADY = v;
  endtask

  task automatic clear_inputs();
    REQ0_ARADDR = '0; REQ1_ARADDR = '0; REQ0_ARVALID = 0; REQ1_ARVALID = 0;
    REQ0_RREADY = 0; REQ1_RREADY = 0; M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
    M_AXI_RDATA = '0; M_AXI_RRESP = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
    model_last = 1;
    cyc();
  endtask

  // Entered in an IDLE cycle just after the edge; leaves in the next IDLE cycle.
  task automatic run_txn(input txn_t t, input string tag);
    int g, k, kexp;
    g    = t.eg;
    kexp = t.eto ? T : t.d;
    REQ0_ARVALID = t.v0; REQ1_ARVALID = t.v1;
    REQ0_ARADDR  = t.a0; REQ1_ARADDR  = t.a1;
    #1;
    chk({tag, "_arready0"}, REQ0_ARREADY, (g == 0));
    chk({tag, "_arready1"}, REQ1_ARREADY, (g == 1));
    if (!(g ? REQ1_ARREADY : REQ0_ARREADY)) begin
      do_reset();
      return;
    end
    cyc();
    #1;
    chk({tag, "_m_arvalid"}, M_AXI_ARVALID, 1);
    chk({tag, "_m_araddr"}, M_AXI_ARADDR, g ? t.a1 : t.a0);
    chk({tag, "_ar_ignored"}, {REQ1_ARREADY, REQ0_ARREADY}, 0);
    chk({tag, "_busy_addr"}, busy, 1);
    for (int w = 0; w < t.arw; w++) begin
      cyc();
      chk({tag, "_m_arvalid_hold"}, M_AXI_ARVALID, 1);
    end
    M_AXI_ARREADY = 1;
    cyc();
    M_AXI_ARREADY = 0;
    for (k = 0; k <= kexp + 2; k++) begin
      M_AXI_RVALID = (!t.eto && k >= t.d);
      M_AXI_RDATA  = M_AXI_RVALID ? t.data : '0;
      M_AXI_RRESP  = M_AXI_RVALID ? t.resp : '0;
      #1;
      if (g_rvalid(g)) break;
      chk({tag, "_quiet"}, {REQ1_RVALID, REQ0_RVALID, timeout}, 0);
      cyc();
    end
    chk({tag, "_latency"}, k, kexp);
    if (k != kexp) begin
      do_reset();
      return;
    end
    chk({tag, "_rdata"}, g_rdata(g), t.edata);
    chk({tag, "_rresp"}, g_rresp(g), t.eresp);
    chk({tag, "_timeout"}, timeout, t.eto);
    chk({tag, "_other_r"}, other_r(g), 0);
    for (int j = 0; j < t.rr; j++) begin
      cyc();
      chk({tag, "_hold_rvalid"}, g_rvalid(g), 1);
      chk({tag, "_hold_rdata"}, g_rdata(g), t.edata);
      chk({tag, "_hold_m_rready"}, M_AXI_RREADY, 0);
      chk({tag, "_hold_timeout"}, timeout, 0);
    end
    set_rready(g, 1);
    #1;
    chk({tag, "_m_rready"}, M_AXI_RREADY, !t.eto);
    cyc();
    set_rready(g, 0);
    M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
    #1;
    if (t.eto) begin
      chk({tag, "_drain_busy"}, busy, 1);
      chk({tag, "_drain_rvalid"}, {REQ1_RVALID, REQ0_RVALID, timeout}, 0);
      chk({tag, "_drain_m_rready"}, M_AXI_RREADY, 1);
      cyc();
      chk({tag, "_drain_wait"}, busy, 1);
      M_AXI_RVALID = 1; M_AXI_RDATA = 32'hBAD0_BAD0;
      cyc();
      M_AXI_RVALID = 0; M_AXI_RDATA = '0;
      #1;
    end
    chk({tag, "_idle_after"}, busy, 0);
    model_last = g;
    $display("txn %s: grant=REQ%0d rresp=%0d rdata=0x%08h timeout=%0d latency=%0d",
             tag, g, t.eresp, t.edata, t.eto, k);
  endtask

  txn_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    txn_t t;
    int v;
    rst = 1'b1;
    clear_inputs();
    tbl[0] = mk(0, 1, 0, 32'h100, 32'h0,   0, 2, 32'hDEADBEEF, 2'b00, 0, 0, 2'b00, 32'hDEADBEEF, 0);
    tbl[1] = mk(1, 1, 1, 32'h200, 32'h300, 0, 0, 32'h11111111, 2'b00, 0, 0, 2'b00, 32'h11111111, 0);
    tbl[2] = mk(0, 1, 1, 32'h204, 32'h304, 0, 1, 32'h22222222, 2'b00, 0, 1, 2'b00, 32'h22222222, 0);
    tbl[3] = mk(0, 1, 1, 32'h208, 32'h308, 0, 0, 32'h33333333, 2'b00, 0, 0, 2'b00, 32'h33333333, 0);
    tbl[4] = mk(0, 1, 1, 32'h20C, 32'h30C, 0, 0, 32'h44444444, 2'b10, 0, 1, 2'b10, 32'h44444444, 0);
    tbl[5] = mk(0, 0, 1, 32'h0,   32'h400, 0, 1, 32'h55555555, 2'b00, 3, 1, 2'b00, 32'h55555555, 0);
    tbl[6] = mk(0, 1, 0, 32'h600, 32'h0,   0, 4, 32'h66666666, 2'b00, 0, 0, 2'b10, 32'h0,        1);
    tbl[7] = mk(0, 0, 1, 32'h0,   32'h700, 0, 3, 32'h77777777, 2'b00, 0, 1, 2'b00, 32'h77777777, 0);
    tbl[8] = mk(0, 1, 0, 32'h800, 32'h0,   2, 0, 32'h88888888, 2'b01, 1, 0, 2'b01, 32'h88888888, 0);
    tbl[9] = mk(0, 0, 1, 32'h0,   32'h900, 0, 6, 32'h99999999, 2'b00, 2, 1, 2'b10, 32'h0,        1);

    cyc();
    cyc();
    chk("reset_outputs", any_out(), 0);
    rst = 1'b0;
    cyc();
    chk("post_reset_idle", any_out(), 0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in DATA right after a REQ0 grant: the next tie must still go to REQ0.
    run_txn(mk(0, 1, 0, 32'h40, 32'h0, 0, 1, 32'hA5A50001, 2'b00, 0, 0, 2'b00, 32'hA5A50001, 0), "pre_rst");
    REQ0_ARVALID = 1; REQ0_ARADDR = 32'h500;
    cyc();
    REQ0_ARVALID = 0;
    M_AXI_ARREADY = 1;
    cyc();
    M_AXI_ARREADY = 0;
    M_AXI_RVALID = 1; M_AXI_RDATA = 32'hCAFEF00D;
    #1;
    chk("rst_pre_rvalid", REQ0_RVALID, 1);
    chk("rst_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", any_out(), 0);
    M_AXI_RVALID = 0; M_AXI_RDATA = '0;
    cyc();
    chk("rst_next_cycle_outputs", any_out(), 0);
    rst = 1'b0;
    model_last = 1;
    cyc();
    run_txn(mk(0, 1, 1, 32'hA00, 32'hB00, 0, 0, 32'h0BADC0DE, 2'b00, 0, 0, 2'b00, 32'h0BADC0DE, 0), "post_rst_tie");

    // Random transactions predicted by the arbitration/timeout rules.
    for (int i = 0; i < 40; i++) begin
      v      = $urandom_range(1, 3);
      t.rst  = 0;
      t.v0   = v[0];
      t.v1   = v[1];
      t.a0   = $urandom;
      t.a1   = $urandom;
      t.arw  = $urandom_range(0, 1);
      t.d    = $urandom_range(0, 5);
      t.data = $urandom;
      t.resp = 2'($urandom_range(0, 3));
      t.rr   = $urandom_range(0, 2);
      t.eg   = (t.v0 && !t.v1) ? 0 : (t.v1 && !t.v0) ? 1 : (model_last == 1 ? 0 : 1);
      t.eto  = (t.d >= T);
      t.eresp = t.eto ? 2'b10 : t.resp;
      t.edata = t.eto ? 32'h0 : t.data;
      run_txn(t, $sformatf("rnd%0d", i));
    end

    clear_inputs();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
